// File: rtl/uart_rx.sv
// 8N1 UART receiver: 16x oversampled, mid-bit sampled, registered one-clk
// push / frame-error / overrun strobes for the RX FIFO.
module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_bit,
    input  logic [DIV_WIDTH-1:0] freq_divider,
    input  logic                 fifo_full,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_error,
    output logic                 overrun,
    output logic                 busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [TW-1:0] MID_CNT  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] LAST_CNT = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    logic                 r_sync1;
    logic                 r_sync2;
    logic [DIV_WIDTH-1:0] r_presc;
    state_t               r_state;
    logic [TW-1:0]        r_tick_cnt;
    logic [BW-1:0]        r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_data_out;
    logic                 r_data_valid;
    logic                 r_frame_error;
    logic                 r_overrun;

    logic                 w_rx_s;
    logic                 w_tick;
    state_t               w_state_nxt;
    logic [TW-1:0]        w_tick_cnt_nxt;
    logic [BW-1:0]        w_bit_idx_nxt;
    logic [DATA_BITS-1:0] w_shift_nxt;
    logic [DATA_BITS-1:0] w_data_out_nxt;
    logic                 w_data_valid_nxt;
    logic                 w_frame_error_nxt;
    logic                 w_overrun_nxt;

    assign w_rx_s = r_sync2;
    // >= rather than == so a divider lowered below the current count wraps at once
    assign w_tick = (r_presc >= freq_divider);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_presc <= '0;
        end else begin
            r_sync1 <= rx_bit;
            r_sync2 <= r_sync1;
            r_presc <= w_tick ? '0 : r_presc + DIV_WIDTH'(1);
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_tick_cnt_nxt    = r_tick_cnt;
        w_bit_idx_nxt     = r_bit_idx;
        w_shift_nxt       = r_shift;
        w_data_out_nxt    = r_data_out;
        w_data_valid_nxt  = 1'b0;
        w_frame_error_nxt = 1'b0;
        w_overrun_nxt     = 1'b0;
        if (w_tick) begin
            case (r_state)
                S_IDLE: begin
                    if (!w_rx_s) begin
                        w_state_nxt    = S_START;
                        w_tick_cnt_nxt = '0;
                    end
                end
                S_START: begin
                    if (r_tick_cnt == MID_CNT) begin
                        w_tick_cnt_nxt = '0;
                        w_bit_idx_nxt  = '0;
                        w_state_nxt    = w_rx_s ? S_IDLE : S_DATA;
                    end else begin
                        w_tick_cnt_nxt = r_tick_cnt + TW'(1);
                    end
                end
                S_DATA: begin
                    if (r_tick_cnt == LAST_CNT) begin
                        w_shift_nxt[r_bit_idx] = w_rx_s;
                        w_tick_cnt_nxt         = '0;
                        if (r_bit_idx == LAST_BIT) w_state_nxt = S_STOP;
                        else w_bit_idx_nxt = r_bit_idx + BW'(1);
                    end else begin
                        w_tick_cnt_nxt = r_tick_cnt + TW'(1);
                    end
                end
                S_STOP: begin
                    if (r_tick_cnt == LAST_CNT) begin
                        w_tick_cnt_nxt = '0;
                        if (!w_rx_s) begin
                            w_frame_error_nxt = 1'b1;
                            w_state_nxt       = S_WAIT_IDLE;
                        end else if (fifo_full) begin
                            w_overrun_nxt = 1'b1;
                            w_state_nxt   = S_IDLE;
                        end else begin
                            w_data_out_nxt   = r_shift;
                            w_data_valid_nxt = 1'b1;
                            w_state_nxt      = S_IDLE;
                        end
                    end else begin
                        w_tick_cnt_nxt = r_tick_cnt + TW'(1);
                    end
                end
                S_WAIT_IDLE: begin
                    if (w_rx_s) w_state_nxt = S_IDLE;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_tick_cnt    <= '0;
            r_bit_idx     <= '0;
            r_shift       <= '0;
            r_data_out    <= '0;
            r_data_valid  <= 1'b0;
            r_frame_error <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_tick_cnt    <= w_tick_cnt_nxt;
            r_bit_idx     <= w_bit_idx_nxt;
            r_shift       <= w_shift_nxt;
            r_data_out    <= w_data_out_nxt;
            r_data_valid  <= w_data_valid_nxt;
            r_frame_error <= w_frame_error_nxt;
            r_overrun     <= w_overrun_nxt;
        end
    end

    assign data_out    = r_data_out;
    assign data_valid  = r_data_valid;
    assign frame_error = r_frame_error;
    assign overrun     = r_overrun;
    assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: serial frames driven bit by bit, expected FIFO-side
// events queued per frame and checked by an independent output monitor.
module tb_uart_rx;

  localparam logic [1:0] K_VALID = 2'd1;
  localparam logic [1:0] K_FERR  = 2'd2;
  localparam logic [1:0] K_OVR   = 2'd3;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx_bit = 1'b1;
  logic [7:0] freq_divider = 8'd0;
  logic       fifo_full = 1'b0;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_error;
  logic       overrun;
  logic       busy;

  always #5 clk = ~clk;

  uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16), .DIV_WIDTH(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_bit       (rx_bit),
    .freq_divider (freq_divider),
    .fifo_full    (fifo_full),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .frame_error  (frame_error),
    .overrun      (overrun),
    .busy         (busy)
  );

  // ---------------- scoreboard ----------------
  logic [9:0] exp_q[$];
  logic [7:0] last_good = 8'h00;
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a frame's outcome depends only on its stop level and fifo_full.
  task automatic model_frame(input logic [7:0] b, input logic stop_v, input logic full);
    if (!stop_v) begin
      exp_q.push_back({K_FERR, last_good});
    end else if (full) begin
      exp_q.push_back({K_OVR, last_good});
    end else begin
      exp_q.push_back({K_VALID, b});
      last_good = b;
    end
  endtask

  // ---------------- monitor ----------------
  logic [9:0] act_ev;
  logic [9:0] exp_ev;
  always @(negedge clk) begin
    if (reset && (data_valid || frame_error || overrun)) begin
      chk("pulse_onehot", 32'(data_valid) + 32'(frame_error) + 32'(overrun), 32'd1);
      act_ev = {(data_valid ? K_VALID : (frame_error ? K_FERR : K_OVR)), data_out};
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: got 0x%0h, expected none at %0t", act_ev, $time);
      end else begin
        exp_ev = exp_q.pop_front();
        chk("event", 32'(act_ev), 32'(exp_ev));
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic drive_bit(input logic v);
    rx_bit = v;
    repeat (16 * (int'(freq_divider) + 1)) @(posedge clk);
    #1;
  endtask

  task automatic idle_bits(input int n);
    for (int i = 0; i < n; i++) drive_bit(1'b1);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v, input logic full);
    fifo_full = full;
    model_frame(b, stop_v, full);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_v);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] b;
    logic       stop_v;
    logic       full;
    int         wait_cnt;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_data_out", 32'(data_out), 32'h0);
    chk("rst_pulses", {29'd0, data_valid, frame_error, overrun}, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    reset = 1'b1;

    // divider 0, single frame
    freq_divider = 8'd0;
    idle_bits(2);
    send_frame(8'h55, 1'b1, 1'b0);
    chk("busy_after_55", 32'(busy), 32'h0);
    idle_bits(1);

    // divider 6, back-to-back frames
    freq_divider = 8'd6;
    idle_bits(2);
    send_frame(8'hA3, 1'b1, 1'b0);
    send_frame(8'h0F, 1'b1, 1'b0);
    chk("busy_after_b2b", 32'(busy), 32'h0);
    idle_bits(1);

    // glitch: 4 ticks low
    rx_bit = 1'b0;
    repeat (4 * (int'(freq_divider) + 1)) @(posedge clk);
    #1;
    rx_bit = 1'b1;
    idle_bits(2);
    chk("glitch_busy", 32'(busy), 32'h0);
    chk("glitch_data_out", 32'(data_out), 32'(last_good));

    // frame error then long break
    freq_divider = 8'd2;
    idle_bits(1);
    send_frame(8'h81, 1'b0, 1'b0);
    chk("ferr_busy", 32'(busy), 32'h1);
    for (int i = 0; i < 40; i++) drive_bit(1'b0);
    chk("break_busy", 32'(busy), 32'h1);
    idle_bits(2);
    chk("break_recovered", 32'(busy), 32'h0);
    send_frame(8'h42, 1'b1, 1'b0);
    idle_bits(1);

    // overrun
    send_frame(8'h7E, 1'b1, 1'b1);
    fifo_full = 1'b0;
    idle_bits(1);
    chk("ovr_data_out_kept", 32'(data_out), 32'h42);

    // reset in the middle of the data bits of 0xFF
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b1);
    chk("busy_mid_frame", 32'(busy), 32'h1);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_data_out", 32'(data_out), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_pulses", {29'd0, data_valid, frame_error, overrun}, 32'h0);
    last_good = 8'h00;
    rx_bit = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    idle_bits(2);
    send_frame(8'h3C, 1'b1, 1'b0);
    idle_bits(1);
    chk("post_rst_data_out", 32'(data_out), 32'h3C);

    // randomized frames
    for (int i = 0; i < 24; i++) begin
      if (i % 6 == 0) begin
        idle_bits(1);
        freq_divider = 8'($urandom_range(0, 3));
        idle_bits(1);
      end
      b      = 8'($urandom_range(0, 255));
      stop_v = ($urandom_range(0, 4) != 0);
      full   = ($urandom_range(0, 3) == 0);
      send_frame(b, stop_v, full);
      fifo_full = 1'b0;
      if (stop_v) begin
        chk("rand_busy_idle", 32'(busy), 32'h0);
        if ($urandom_range(0, 1) == 1) idle_bits(1);
      end else begin
        chk("rand_busy_ferr", 32'(busy), 32'h1);
        idle_bits(1);
      end
    end
    idle_bits(2);

    // drain
    wait_cnt = 0;
    while (exp_q.size() != 0 && wait_cnt < 4000) begin
      @(posedge clk);
      wait_cnt++;
    end
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receive half of the UART: recovers 8N1 frames from `rx_bit` and presents each byte for pushing into the RX FIFO.
- Uses 16x oversampling with mid-bit sampling.
- Runs on `clk` with the same divider semantics as the TX path: tick period = `freq_divider` + 1 clk cycles, 16 ticks per bit.
- Sits between the `rx_bit` pad and the RX FIFO push/data_in; the Wishbone side reads through the FIFO.

Parameters:
- DATA_BITS, 8, data bits per frame, LSB first
- OVERSAMPLE, 16, ticks per bit period; mid-bit sample at OVERSAMPLE/2
- DIV_WIDTH, 8, width of `freq_divider`

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- rx_bit  input  1  serial line, asynchronous to clk, idle high
- freq_divider  input  DIV_WIDTH  tick divider; 6 for 12 MHz / 115200
- fifo_full  input  1  RX FIFO full flag
- data_out  output  DATA_BITS  received byte, to FIFO data_in
- data_valid  output  1  one-clk push strobe to RX FIFO
- frame_error  output  1  one-clk pulse: stop bit sampled low
- overrun  output  1  one-clk pulse: byte dropped because fifo_full=1
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; prescaler, tick_cnt and bit_idx = 0.
  - Synchronizer flops = 1.
  - data_out=0; data_valid, frame_error, overrun and busy = 0.
- Synchronizer: `rx_bit` passes through 2 flops; `rx_s` is the second flop. All decisions use `rx_s`, so there is 2 clk of input latency.
- Tick generator:
  - Prescaler counts 0..`freq_divider`. When it equals `freq_divider`, tick=1 for one clk and the prescaler wraps to 0.
  - `freq_divider`=0 gives a tick every clk.
  - The prescaler is free-running and is not restarted on start detection.
  - `freq_divider` is read live. Changing it mid-frame is legal but corrupts that frame.
- FSM: all transitions happen on clk edges where tick=1. Outside ticks, the state is held.
  - IDLE: if `rx_s`=0, go to START with tick_cnt=0.
  - START: if tick_cnt==7, check `rx_s`:
    - `rx_s`=0: go to DATA with tick_cnt=0 and bit_idx=0.
    - `rx_s`=1: treat as a glitch and return to IDLE with no output pulse.
    - If tick_cnt≠7, tick_cnt++.
  - DATA: if tick_cnt==15, shift `rx_s` into shift register bit[bit_idx] (LSB first) and set tick_cnt=0.
    - If bit_idx==DATA_BITS-1, go to STOP; otherwise bit_idx++.
    - If tick_cnt≠15, tick_cnt++.
  - STOP: if tick_cnt==15, check `rx_s`:
    - `rx_s`=1 and fifo_full=0: data_out←shift register, data_valid=1, go to IDLE.
    - `rx_s`=1 and fifo_full=1: overrun=1, data_out unchanged, no data_valid, go to IDLE.
    - `rx_s`=0: frame_error=1, no data_valid, go to WAIT_IDLE.
    - If tick_cnt≠15, tick_cnt++.
  - WAIT_IDLE (break/line-low recovery): go to IDLE on the first tick with `rx_s`=1.
- Output pulses:
  - data_valid, frame_error and overrun are registered.
  - Each is high exactly one clk, on the clk after the tick edge that decides the stop bit.
  - At most one of the three is high in any cycle.
- data_out holds the last good byte until the next data_valid.
- A start bit is re-armed only from IDLE. A falling edge in the same tick that STOP returns to IDLE is detected on the next tick.
- Continuous back-to-back frames (stop bit immediately followed by start bit) must be received without loss.

Test Plan:
- `freq_divider`=0, send 0x55 8N1 at 16 clk/bit -> one data_valid pulse, data_out=0x55, frame_error=0, busy falls after the stop bit.
- `freq_divider`=6, send 0xA3 then 0x0F back-to-back with no idle gap -> two data_valid pulses with data_out 0xA3 then 0x0F.
- Glitch: `rx_bit` low for 4 ticks, then high -> FSM returns to IDLE, no pulses, data_out unchanged.
- Frame error: send 0x81 with the stop bit low, then hold the line low for 40 bit times -> exactly one frame_error pulse, busy high until the line returns high, next 0x42 frame received correctly.
- fifo_full=1 during the stop bit of 0x7E -> one overrun pulse, no data_valid, data_out keeps the previous byte.
- Assert reset mid-DATA of 0xFF -> outputs zero immediately; after release, line idle, send 0x3C -> data_out=0x3C with no spurious pulse.
